// File: rtl/div_pkg.sv
// div_pkg: shared definitions for the RV32M divide unit.
//   - OP_* : funct3[1:0] encodings of the four divide/remainder ops.
//             bit 1 selects remainder, bit 0 selects unsigned.
//   - state_t : divider FSM state encoding (2 bits).
package div_pkg;

  localparam logic [1:0] OP_DIV  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
  localparam logic [1:0] OP_REM  = 2'b10;
  localparam logic [1:0] OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/adder_n_subtractor.sv
// adder_n_subtractor: N-bit adder / subtractor.
//   a   in  N : operand subtracted when c=1
//   b   in  N : base operand
//   c   in  1 : 0 -> sum = b + a, 1 -> sum = b - a
//   sum out N : result, modulo 2^N
module adder_n_subtractor #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c,
  output logic [N-1:0] sum
);

  // Subtraction as b + ~a + 1: c both inverts a and supplies the carry-in.
  assign sum = b + (a ^ {N{c}}) + {{(N-1){1'b0}}, c};

endmodule

// File: rtl/div_unit.sv
// div_unit: sequential restoring divider for DIV, DIVU, REM, REMU.
//   clk       in  1    : clock, rising edge
//   reset     in  1    : asynchronous active-high reset
//   start     in  1    : request strobe, only looked at in IDLE
//   op        in  2    : funct3[1:0] (see div_pkg)
//   dividend  in  XLEN : rs1, captured on the accepted start
//   divisor   in  XLEN : rs2, captured on the accepted start
//   busy      out 1    : state != IDLE
//   done      out 1    : one-cycle pulse, result valid from here on
//   result    out XLEN : quotient or remainder, held until next result load
//   state_dbg out 2    : current FSM state, for observation only
//
// Handshake: a request is accepted on any rising edge where state is IDLE
// and start=1; operands are needed only in that cycle. There is no
// back-pressure on the result: done pulses once and result stays put.
// start while busy is dropped, not queued.
module div_unit
  import div_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output state_t          state_dbg
);

  localparam int CW = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_q, state_d;
  logic [XLEN-1:0] q_q, q_d;          // dividend shifting out / quotient in
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            rem_sel_q, rem_sel_d;
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic [XLEN-1:0] result_q, result_d;

  logic [XLEN:0]   shifted;
  logic [XLEN:0]   trial;
  logic            is_signed;
  logic            div_zero;
  logic            ovf;

  assign shifted = {rem_q, q_q[XLEN-1]};

  adder_n_subtractor #(.N(XLEN + 1)) u_trial (
    .a   ({1'b0, dvs_q}),
    .b   (shifted),
    .c   (1'b1),
    .sum (trial)
  );

  assign is_signed = ~op[0];
  assign div_zero  = (divisor == '0);
  assign ovf       = is_signed && (dividend == MIN_NEG) && (&divisor);

  always_comb begin
    state_d   = state_q;
    q_d       = q_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    cnt_d     = cnt_q;
    rem_sel_d = rem_sel_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_sel_d = op[1];
          q_neg_d   = is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
          r_neg_d   = is_signed & dividend[XLEN-1];
          q_d       = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
          dvs_d     = (is_signed && divisor[XLEN-1]) ? -divisor : divisor;
          rem_d     = '0;
          cnt_d     = CW'(XLEN);
          if (div_zero) begin
            result_d = op[1] ? dividend : '1;
            state_d  = DONE;
          end else if (ovf) begin
            // The most negative value divided by -1 wraps back to itself.
            result_d = op[1] ? '0 : MIN_NEG;
            state_d  = DONE;
          end else begin
            state_d  = CALC;
          end
        end
      end
      CALC: begin
        // A clear top bit on the trial means no borrow: the divisor fits.
        if (!trial[XLEN]) begin
          rem_d = trial[XLEN-1:0];
          q_d   = {q_q[XLEN-2:0], 1'b1};
        end else begin
          rem_d = shifted[XLEN-1:0];
          q_d   = {q_q[XLEN-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        if (rem_sel_q) result_d = r_neg_q ? -rem_q : rem_q;
        else           result_d = q_neg_q ? -q_q : q_q;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      cnt_q     <= cnt_d;
      rem_sel_q <= rem_sel_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
      result_q  <= result_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign result    = result_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed vector table, hand-written corner sequences and a
// randomized sweep against a RISC-V M reference model.
module tb_div_unit;
  import div_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  state_t      state_dbg;

  int total;
  int bad;

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_model(input logic [1:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Waits one edge (so a call right after done lands in the first IDLE
  // cycle), raises start for one cycle, then scrambles the operand inputs
  // and counts edges until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output logic busy_seen);
    @(posedge clk); #1;
    start = 1'b1; op = o; dividend = a; divisor = b;
    lat = 0; busy_seen = 1'b0; res = '0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) begin
        busy_seen = busy;
        start = 1'b0;
        op = 2'($urandom);
        dividend = $urandom;
        divisor = $urandom;
      end
      if (done) begin
        res = result;
        break;
      end
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL timeout: done not seen after %0d cycles, required within 100", lat);
      lat = -1;
    end
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  localparam int NV = 18;
  vec_t vt[NV];

  initial begin
    logic [31:0] res;
    logic        bsy;
    int          lat;
    int          pulses;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [1:0]  ro;
    int          sel;

    total = 0;
    bad = 0;

    vt[0]  = '{OP_DIVU, 32'd100,        32'd7,          32'd14,         34};
    vt[1]  = '{OP_REMU, 32'd100,        32'd7,          32'd2,          34};
    vt[2]  = '{OP_DIV,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFF2,  34};
    vt[3]  = '{OP_REM,  32'hFFFF_FF9C,  32'd7,          32'hFFFF_FFFE,  34};
    vt[4]  = '{OP_REM,  32'd100,        32'hFFFF_FFF9,  32'd2,          34};
    vt[5]  = '{OP_DIV,  32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vt[6]  = '{OP_DIVU, 32'd5,          32'd0,          32'hFFFF_FFFF,  1};
    vt[7]  = '{OP_REM,  32'd5,          32'd0,          32'd5,          1};
    vt[8]  = '{OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  1};
    vt[9]  = '{OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          1};
    vt[10] = '{OP_DIVU, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  34};
    vt[11] = '{OP_REMU, 32'hFFFF_FFFF,  32'h10,         32'hF,          34};
    vt[12] = '{OP_DIV,  32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  34};
    vt[13] = '{OP_REM,  32'd7,          32'hFFFF_FFFE,  32'd1,          34};
    vt[14] = '{OP_DIV,  32'd0,          32'd5,          32'd0,          34};
    vt[15] = '{OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          34};
    vt[16] = '{OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  34};
    vt[17] = '{OP_REM,  32'hFFFF_FFFB,  32'd0,          32'hFFFF_FFFB,  1};

    // ---------------- reset ----------------
    reset = 1'b1; start = 1'b0; op = '0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_result", result, 32'd0);
    chk("reset_state", 32'(state_dbg), 32'(IDLE));

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, bsy);
      chk($sformatf("vec%0d_result", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_busy", i), 32'(bsy), 32'd1);
    end

    // ---------------- start during CALC is ignored ----------------
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    lat = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (lat == 5) begin
        start = 1'b1; op = OP_REMU; dividend = 32'd1000; divisor = 32'd3;
      end
      if (lat == 6) start = 1'b0;
      if (done) break;
    end
    chk("calc_start_result", result, 32'd14);
    chk("calc_start_latency", 32'(lat), 32'd34);

    // start while in DONE is ignored too
    start = 1'b1; op = OP_REMU; dividend = 32'd1000; divisor = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_start_busy", 32'(busy), 32'd0);
    chk("done_start_result", result, 32'd14);

    // ---------------- reset mid-CALC ----------------
    @(posedge clk); #1;
    start = 1'b1; op = OP_DIVU; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_result", result, 32'd0);
    chk("midreset_state", 32'(state_dbg), 32'(IDLE));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pulses = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("midreset_no_done", 32'(pulses), 32'd0);
    run_op(OP_DIVU, 32'd9, 32'd3, res, lat, bsy);
    chk("after_reset_result", res, 32'd3);
    chk("after_reset_latency", 32'(lat), 32'd34);

    // ---------------- random back-to-back sweep ----------------
    for (int o = 0; o < 4; o++) begin
      for (int i = 0; i < 150; i++) begin
        ro = 2'(o);
        ra = $urandom;
        sel = $urandom_range(0, 9);
        case (sel)
          0:       rb = 32'h0;
          1:       rb = 32'hFFFF_FFFF;
          2:       rb = $urandom_range(1, 15);
          3:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
          4:       begin ra = $urandom_range(0, 1000); rb = $urandom; end
          default: rb = $urandom;
        endcase
        run_op(ro, ra, rb, res, lat, bsy);
        chk($sformatf("rand_op%0d_%0h_%0h", o, ra, rb), res, ref_model(ro, ra, rb));
        chk($sformatf("rand_lat_op%0d_%0h_%0h", o, ra, rb), 32'(lat),
            ((rb == 32'h0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF))
              ? 32'd1 : 32'd34);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
